// File: rtl/pan_ascii_framer.sv
// ASCII byte stream to PAN digit framing: strips separators, bounds length,
// enforces inter-character timeout and discards malformed frames to their terminator.
module pan_ascii_framer #(
  parameter int unsigned MAX_DIGITS     = 19,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TO_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       start,
  output logic       digit_valid,
  output logic [3:0] digit_in,
  output logic       pan_end,
  output logic       abort,
  output logic       busy,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [4:0] digit_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_START   = 2'd1;
  localparam logic [1:0] S_DIGITS  = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  localparam logic [1:0] E_NONE    = 2'd0;
  localparam logic [1:0] E_BAD     = 2'd1;
  localparam logic [1:0] E_LONG    = 2'd2;
  localparam logic [1:0] E_TIMEOUT = 2'd3;

  logic [1:0]      state, state_nx;
  logic [3:0]      hold, hold_nx;
  logic [TO_W-1:0] idle_cnt, idle_cnt_nx;
  logic            start_nx, digit_valid_nx, pan_end_nx, abort_nx, frame_err_nx;
  logic [3:0]      digit_in_nx;
  logic [1:0]      err_code_nx;
  logic [4:0]      digit_count_nx;
  logic            accept, is_dig, is_sep, is_term, is_esc, timed_out;

  assign byte_ready = !rst && (state != S_START);
  assign busy       = (state != S_IDLE);
  assign accept     = byte_valid && byte_ready;

  // Character classification
  assign is_dig  = (byte_in >= 8'h30) && (byte_in <= 8'h39);
  assign is_sep  = (byte_in == 8'h20) || (byte_in == 8'h2D);
  assign is_term = (byte_in == 8'h0D) || (byte_in == 8'h0A);
  assign is_esc  = (byte_in == 8'h1B);

  assign timed_out = (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Next-state and next-output logic
  always_comb begin
    state_nx       = state;
    hold_nx        = hold;
    idle_cnt_nx    = '0;
    start_nx       = 1'b0;
    digit_valid_nx = 1'b0;
    digit_in_nx    = digit_in;
    pan_end_nx     = 1'b0;
    abort_nx       = 1'b0;
    frame_err_nx   = frame_err;
    err_code_nx    = err_code;
    digit_count_nx = digit_count;
    case (state)
      S_IDLE: begin
        if (accept && is_dig) begin
          hold_nx  = byte_in[3:0];
          start_nx = 1'b1;
          state_nx = S_START;
        end
      end
      S_START: begin
        digit_valid_nx = 1'b1;
        digit_in_nx    = hold;
        digit_count_nx = 5'd1;
        frame_err_nx   = 1'b0;
        err_code_nx    = E_NONE;
        state_nx       = S_DIGITS;
      end
      S_DIGITS: begin
        if (accept) begin
          if (is_dig) begin
            if (digit_count < 5'(MAX_DIGITS)) begin
              digit_valid_nx = 1'b1;
              digit_in_nx    = byte_in[3:0];
              digit_count_nx = digit_count + 5'd1;
            end else begin
              abort_nx     = 1'b1;
              err_code_nx  = E_LONG;
              frame_err_nx = 1'b1;
              state_nx     = S_DISCARD;
            end
          end else if (is_sep) begin
            state_nx = S_DIGITS;
          end else if (is_term) begin
            pan_end_nx = 1'b1;
            state_nx   = S_IDLE;
          end else if (is_esc) begin
            abort_nx    = 1'b1;
            err_code_nx = E_NONE;
            state_nx    = S_IDLE;
          end else begin
            abort_nx     = 1'b1;
            err_code_nx  = E_BAD;
            frame_err_nx = 1'b1;
            state_nx     = S_DISCARD;
          end
        end else if (timed_out) begin
          abort_nx     = 1'b1;
          err_code_nx  = E_TIMEOUT;
          frame_err_nx = 1'b1;
          state_nx     = S_IDLE;
        end else begin
          idle_cnt_nx = idle_cnt + TO_W'(1);
        end
      end
      default: begin
        if (accept && (is_term || is_esc)) state_nx = S_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      hold        <= '0;
      idle_cnt    <= '0;
      start       <= 1'b0;
      digit_valid <= 1'b0;
      digit_in    <= '0;
      pan_end     <= 1'b0;
      abort       <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= '0;
      digit_count <= '0;
    end else begin
      state       <= state_nx;
      hold        <= hold_nx;
      idle_cnt    <= idle_cnt_nx;
      start       <= start_nx;
      digit_valid <= digit_valid_nx;
      digit_in    <= digit_in_nx;
      pan_end     <= pan_end_nx;
      abort       <= abort_nx;
      frame_err   <= frame_err_nx;
      err_code    <= err_code_nx;
      digit_count <= digit_count_nx;
    end
  end

endmodule

// File: tb/tb_pan_ascii_framer.sv
// Bench for pan_ascii_framer: directed plan steps plus randomized frames
// checked against a byte-level frame model.
module tb_pan_ascii_framer;

  localparam int unsigned MAXD = 19;
  localparam int unsigned TOC  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready, start, digit_valid, pan_end, abort, busy, frame_err;
  logic [3:0] digit_in;
  logic [1:0] err_code;
  logic [4:0] digit_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  int         m_mode;
  int         m_cnt;
  logic       m_ferr;
  logic [1:0] m_ecode;

  localparam logic [3:0] EV_START = 4'h1, EV_DIG = 4'h2, EV_END = 4'h3, EV_ABORT = 4'h4;

  pan_ascii_framer #(.MAX_DIGITS(MAXD), .TIMEOUT_CYCLES(TOC), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .start(start), .digit_valid(digit_valid),
    .digit_in(digit_in), .pan_end(pan_end), .abort(abort), .busy(busy),
    .frame_err(frame_err), .err_code(err_code), .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Event monitor, sampled mid-cycle
  always @(negedge clk) begin
    int n;
    n = int'(start) + int'(digit_valid) + int'(pan_end) + int'(abort);
    if (n > 1) chk("pulse_onehot", 32'(n), 32'd1);
    if (start)       got_q.push_back({EV_START, 4'h0});
    if (digit_valid) got_q.push_back({EV_DIG, digit_in});
    if (pan_end)     got_q.push_back({EV_END, 4'h0});
    if (abort)       got_q.push_back({EV_ABORT, 4'h0});
  end

  // Frame-level reference: what each accepted byte means for the PAN frame
  function automatic void model_step(input logic [7:0] b);
    logic dig, term, esc, sep;
    dig  = (b >= "0") && (b <= "9");
    term = (b == 8'h0D) || (b == 8'h0A);
    esc  = (b == 8'h1B);
    sep  = (b == " ") || (b == "-");
    if (m_mode == 0) begin
      if (dig) begin
        exp_q.push_back({EV_START, 4'h0});
        exp_q.push_back({EV_DIG, 4'(b - "0")});
        m_cnt = 1; m_ferr = 1'b0; m_ecode = 2'd0; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (dig && m_cnt < int'(MAXD)) begin
        exp_q.push_back({EV_DIG, 4'(b - "0")});
        m_cnt++;
      end else if (dig) begin
        exp_q.push_back({EV_ABORT, 4'h0});
        m_ecode = 2'd2; m_ferr = 1'b1; m_mode = 2;
      end else if (term) begin
        exp_q.push_back({EV_END, 4'h0});
        m_mode = 0;
      end else if (esc) begin
        exp_q.push_back({EV_ABORT, 4'h0});
        m_ecode = 2'd0; m_mode = 0;
      end else if (!sep) begin
        exp_q.push_back({EV_ABORT, 4'h0});
        m_ecode = 2'd1; m_ferr = 1'b1; m_mode = 2;
      end
    end else if (term || esc) begin
      m_mode = 0;
    end
  endfunction

  task automatic send(input logic [7:0] b);
    int g;
    @(negedge clk);
    byte_in = b; byte_valid = 1'b1; g = 0;
    while (!byte_ready && g < 4) begin
      @(negedge clk);
      g++;
    end
    if (!byte_ready) chk("ready_wait", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    model_step(b);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic gap(input int n);
    byte_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_events(input string tag);
    int n;
    gap(3);
    chk({tag, "_ev_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_ev"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
    chk({tag, "_count"}, 32'(digit_count), 32'(m_cnt));
    chk({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
    chk({tag, "_ecode"}, 32'(err_code), 32'(m_ecode));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    string s;
    rst = 1'b1; byte_valid = 1'b0; byte_in = 8'h00;
    m_mode = 0; m_cnt = 0; m_ferr = 1'b0; m_ecode = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(byte_ready), 32'd0);
    chk("reset_outs", {start, digit_valid, pan_end, abort, busy, frame_err, err_code, digit_count}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready", 32'(byte_ready), 32'd1);

    // 1: good frame with separators
    send("4");
    chk("t1_start_stall", {byte_ready, start}, 32'b01);
    send_str("111 1111-1111 1111");
    send(8'h0D);
    chk("t1_pan_end", 32'(pan_end), 32'd1);
    check_events("t1");
    chk("t1_count16", 32'(digit_count), 32'd16);

    // 2: overlong frame
    send_str("12345678901234567890");
    chk("t2_abort", {abort, err_code, frame_err}, {1'b1, 2'd2, 1'b1});
    send(8'h0A);
    check_events("t2");

    // 3: bad character then a clean frame
    send_str("12A");
    chk("t3_abort", {abort, err_code}, {1'b1, 2'd1});
    send_str("34");
    send(8'h0A);
    send_str("7");
    send(8'h0D);
    check_events("t3");

    // 4: timeout after "123"
    send_str("123");
    gap(TOC - 1);
    chk("t4_no_abort_early", 32'(abort), 32'd0);
    gap(1);
    chk("t4_abort", {abort, err_code, frame_err, busy}, {1'b1, 2'd3, 1'b1, 1'b0});
    exp_q.push_back({EV_ABORT, 4'h0});
    m_ecode = 2'd3; m_ferr = 1'b1; m_mode = 0;
    check_events("t4");
    // 4b: accept on the would-be timeout edge wins
    send_str("12");
    gap(TOC - 1);
    byte_in = "3"; byte_valid = 1'b1;
    @(posedge clk);
    #1;
    model_step("3");
    chk("t4b_no_abort", {abort, digit_valid, digit_in}, {1'b0, 1'b1, 4'd3});
    send(8'h0D);
    check_events("t4b");

    // 5: user abort
    send_str("55");
    send(8'h1B);
    chk("t5_abort", {abort, err_code, frame_err}, {1'b1, 2'd0, 1'b0});
    send_str("5");
    send(8'h0D);
    check_events("t5");

    // 6: reset mid-frame
    send_str("98765");
    byte_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_ready_in_reset", 32'(byte_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6_outs", {start, digit_valid, pan_end, abort, busy, frame_err, err_code, digit_count}, 32'd0);
    m_mode = 0; m_cnt = 0; m_ferr = 1'b0; m_ecode = 2'd0;
    gap(2);
    send("9");
    chk("t6_fresh_start", 32'(start), 32'd1);
    send(8'h0D);
    check_events("t6");

    // Randomized frames with short gaps (below the timeout)
    for (int f = 0; f < 40; f++) begin
      int len, kind;
      s = "";
      if ($urandom_range(0, 3) == 0) s = {s, "x "};
      len = $urandom_range(1, 22);
      kind = $urandom_range(0, 7);
      for (int i = 0; i < len; i++) begin
        s = {s, string'(8'("0" + $urandom_range(0, 9)))};
        if ($urandom_range(0, 3) == 0) s = {s, ($urandom_range(0, 1) == 0) ? " " : "-"};
        if (kind == 0 && i == len / 2) s = {s, string'(8'("A" + $urandom_range(0, 25)))};
      end
      if (kind == 1) s = {s, string'(8'h1B)};
      else s = {s, string'(($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A)};
      for (int i = 0; i < s.len(); i++) begin
        if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 3));
        send(s[i]);
      end
      check_events("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
